// File: rtl/cnn_fifo_pkg.sv
// Shared defaults and helpers for the CNN datapath FIFOs.
package cnn_fifo_pkg;
   localparam int CNN_FIFO_DATA_W = 8;
   localparam int CNN_FIFO_DEPTH  = 256;

   function automatic int cnn_clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/fifo_dp_mem.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write, read port sync or async by SYNC_RD.
module fifo_dp_mem
   import cnn_fifo_pkg::*;
#(
   parameter int DATA_W  = CNN_FIFO_DATA_W,
   parameter int DEPTH   = CNN_FIFO_DEPTH,
   parameter int ADDR_W  = cnn_clog2(DEPTH),
   parameter bit SYNC_RD = 1'b1
) (
   input  logic              w_clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge w_clk)
      if (we) mem_q[waddr] <= wdata;

   generate
      if (SYNC_RD) begin : g_sync
         // Output register is reset so the read word is defined from the start.
         logic [DATA_W-1:0] rdata_q;
         always_ff @(posedge w_clk)
            if (reset)   rdata_q <= '0;
            else if (re) rdata_q <= mem_q[raddr];
         assign rdata = rdata_q;
      end else begin : g_async
         logic unused_rd;
         assign unused_rd = reset ^ re;
         assign rdata     = mem_q[raddr];
      end
   endgenerate
endmodule

// File: rtl/cnn_sync_fifo.sv
// Parametrised single-clock FIFO with count, threshold flags and sticky error flags.
// Define CNN_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module cnn_sync_fifo
   import cnn_fifo_pkg::*;
#(
   parameter  int DATA_W    = CNN_FIFO_DATA_W,
   parameter  int DEPTH     = CNN_FIFO_DEPTH,
   parameter  int AF_THRESH = DEPTH - 2,
   parameter  int AE_THRESH = 2,
   localparam int ADDR_W    = cnn_clog2(DEPTH)
) (
   input  logic              w_clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

   logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d, unf_q, unf_d;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] mem_rdata;

   // Flags decode straight from the registered count; no pointer compare.
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   assign wr_acc       = wr_en & ~full;
   assign rd_acc       = rd_en & ~empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q | (wr_en & full);
      unf_d   = unf_q | (rd_en & empty);
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
      if (clear) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end
   end

   always_ff @(posedge w_clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

`ifdef CNN_FIFO_FWFT_EN
   localparam bit SYNC_RD = 1'b0;
   // Head word is presented combinationally; masked to zero while empty.
   assign rd_data  = empty ? '0 : mem_rdata;
   assign rd_valid = ~empty;
`else
   localparam bit SYNC_RD = 1'b1;
   logic rvalid_q, rvalid_d;

   always_comb begin
      rvalid_d = rd_acc & ~clear;
   end

   always_ff @(posedge w_clk) begin
      if (reset) rvalid_q <= 1'b0;
      else       rvalid_q <= rvalid_d;
   end

   assign rd_data  = mem_rdata;
   assign rd_valid = rvalid_q;
`endif

   // clear suppresses the memory ports so a flushed read leaves rd_data untouched.
   fifo_dp_mem #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .SYNC_RD (SYNC_RD)
   ) u_mem (
      .w_clk (w_clk),
      .reset (reset),
      .we    (wr_acc & ~clear),
      .waddr (wptr_q),
      .wdata (wr_data),
      .re    (rd_acc & ~clear),
      .raddr (rptr_q),
      .rdata (mem_rdata)
   );
endmodule

// File: tb/tb_cnn_sync_fifo.sv
// Self-checking bench for cnn_sync_fifo at DEPTH=8, AF=6, AE=2 against a queue model.
module tb_cnn_sync_fifo;
   localparam int DW = 8;
   localparam int DP = 8;
   localparam int AF = 6;
   localparam int AE = 2;

   logic          w_clk = 1'b0;
   logic          reset, clear, wr_en, rd_en;
   logic [DW-1:0] wr_data, rd_data;
   logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0]    count;

   cnn_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .w_clk(w_clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 w_clk = ~w_clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model: contents as a queue, plus sticky flags and last delivered word
   logic [DW-1:0] mq[$];
   logic          m_ov, m_un, m_rv;
   logic [DW-1:0] m_rd;

   task automatic model_reset();
      mq.delete();
      m_ov = 0; m_un = 0; m_rv = 0; m_rd = '0;
   endtask

   task automatic model_edge(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
      int n;
      n = mq.size();
      if (c) begin
         mq.delete();
         m_ov = 0; m_un = 0; m_rv = 0;
      end else begin
         if (w && n == DP) m_ov = 1;
         if (r && n == 0)  m_un = 1;
         m_rv = (r && n > 0);
         if (m_rv) m_rd = mq.pop_front();
         if (w && n < DP) mq.push_back(d);
      end
   endtask

   task automatic check(input string tag);
      int n;
      logic ev;
      logic [DW-1:0] ed;
      n = mq.size();
`ifdef CNN_FIFO_FWFT_EN
      ev = (n != 0);
      ed = (n != 0) ? mq[0] : '0;
`else
      ev = m_rv;
      ed = m_rd;
`endif
      vectors++;
      if (count !== n[3:0] || full !== (n == DP) || empty !== (n == 0) ||
          almost_full !== (n >= AF) || almost_empty !== (n <= AE) ||
          overflow !== m_ov || underflow !== m_un || rd_valid !== ev || rd_data !== ed) begin
         miscompares++;
         $display("FAIL %s: got cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b rv=%b rd=%h, want cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b rv=%b rd=%h",
                  tag, count, full, empty, almost_full, almost_empty, overflow, underflow, rd_valid, rd_data,
                  n, (n == DP), (n == 0), (n >= AF), (n <= AE), m_ov, m_un, ev, ed);
      end
   endtask

   // drive at negedge, clock, update model, check at next negedge
   task automatic step(input logic c, input logic w, input logic [DW-1:0] d, input logic r, input string tag);
      clear = c; wr_en = w; wr_data = d; rd_en = r;
      @(posedge w_clk);
      model_edge(c, w, d, r);
      @(negedge w_clk);
      check(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      @(posedge w_clk);
      model_reset();
      @(negedge w_clk);
      reset = 1'b0;
      check(tag);
   endtask

   typedef struct {
      logic          clr, we, re;
      logic [DW-1:0] wd;
      int            cnt;
      logic          ov, un;
   } vec_t;

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{0, 1, 0, 8'h01, 1, 0, 0};
      tbl[1]  = '{0, 1, 0, 8'h02, 2, 0, 0};
      tbl[2]  = '{0, 1, 0, 8'h03, 3, 0, 0};
      tbl[3]  = '{0, 1, 0, 8'h04, 4, 0, 0};
      tbl[4]  = '{0, 0, 1, 8'h00, 3, 0, 0};
      tbl[5]  = '{0, 0, 1, 8'h00, 2, 0, 0};
      tbl[6]  = '{0, 0, 1, 8'h00, 1, 0, 0};
      tbl[7]  = '{0, 0, 1, 8'h00, 0, 0, 0};
      tbl[8]  = '{0, 0, 1, 8'h00, 0, 0, 1};
      tbl[9]  = '{1, 1, 1, 8'h77, 0, 0, 0};
      tbl[10] = '{0, 1, 1, 8'h55, 1, 0, 1};

      reset = 1'b1; clear = 0; wr_en = 0; rd_en = 0; wr_data = '0;
      @(negedge w_clk);
      do_reset("reset");

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].clr, tbl[i].we, tbl[i].wd, tbl[i].re, $sformatf("tbl%0d", i));
         vectors++;
         if (count !== tbl[i].cnt[3:0] || overflow !== tbl[i].ov || underflow !== tbl[i].un) begin
            miscompares++;
            $display("FAIL tbl%0d_exp: got cnt=%0d ov=%b un=%b, want cnt=%0d ov=%b un=%b",
                     i, count, overflow, underflow, tbl[i].cnt, tbl[i].ov, tbl[i].un);
         end
      end
      step(0, 0, 0, 1, "drain");
      step(1, 0, 0, 0, "clr0");

      // fill to full, then one overflowing write, then drain in order
      for (int i = 0; i < DP; i++) step(0, 1, 8'h10 + 8'(i), 0, "fill");
      step(0, 1, 8'hEE, 0, "ovf_write");
      step(0, 1, 8'hEF, 1, "full_wr_rd");
      for (int i = 0; i < DP; i++) step(0, 0, 0, 1, "drain_full");
      step(1, 0, 0, 0, "clr1");

      // pointer wrap past DEPTH-1
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 6; i++) step(0, 1, 8'h30 + 8'(k*6+i), 0, "wrap_w");
         for (int i = 0; i < 6; i++) step(0, 0, 0, 1, "wrap_r");
      end

      // simultaneous read/write at count 3, then both on empty
      for (int i = 0; i < 3; i++) step(0, 1, 8'h50 + 8'(i), 0, "sim_pre");
      for (int i = 0; i < 4; i++) step(0, 1, 8'h60 + 8'(i), 1, "sim_rw");
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, "sim_drain");
      step(0, 1, 8'h99, 1, "empty_wr_rd");
      step(0, 0, 0, 1, "sim_last");

      // clear mid-stream with a read pending, then rd_valid must be gone
      for (int i = 0; i < 5; i++) step(0, 1, 8'hA0 + 8'(i), 0, "pre_clr");
      step(0, 0, 0, 1, "rd_before_clr");
      step(1, 1, 8'hFF, 1, "clr_mid");
      step(0, 0, 0, 0, "post_clr");

      // reset mid-stream
      for (int i = 0; i < 4; i++) step(0, 1, 8'hC0 + 8'(i), 0, "pre_rst");
      rd_en = 1'b1;
      do_reset("rst_mid");
      rd_en = 1'b0;
      step(0, 0, 0, 0, "post_rst");

      // randomized traffic with phase-biased read/write probability
      for (int i = 0; i < 3000; i++) begin
         int ph, pw, pr;
         logic c, w, r;
         ph = (i / 150) % 3;
         pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
         pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
         c = ($urandom_range(0, 99) < 2);
         w = ($urandom_range(0, 99) < pw);
         r = ($urandom_range(0, 99) < pr);
         step(c, w, 8'($urandom), r, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
